// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: ImmSrc encoding, skid-buffer
// occupancy states and the XLEN legality check.
package imm_gen_stage_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMM_SRC_W  = 3;
  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned DEF_TAG_W  = 5;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_RSV6 = 3'b110,
    IMM_RSV7 = 3'b111
  } imm_src_t;

  // Number of valid entries held by the stage (main + skid)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus between decode, the immediate stage and execute, plus the flush line.
interface imm_gen_stage_if
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAG_W = DEF_TAG_W
);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  imm_src_t           in_imm_src;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  logic [TAG_W-1:0]   out_tag;
  logic               out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: extracts the ImmSrc-selected field from an
// instruction word and sign-extends it to XLEN; reserved codes yield 0 + illegal.
module imm_gen_stage_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  imm_src_t           i_imm_src,
  output logic [XLEN-1:0]    o_imm_c,
  output logic               o_illegal_c
);

  logic [31:0] w_imm32;
  logic        w_unused_opcode;

  // Opcode bits never carry immediate data
  assign w_unused_opcode = ^i_instr[6:0];

  always_comb begin
    w_imm32     = '0;
    o_illegal_c = 1'b0;
    case (i_imm_src)
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      IMM_Z: w_imm32 = {27'b0, i_instr[19:15]};
      default: begin
        w_imm32     = '0;
        o_illegal_c = 1'b1;
      end
    endcase
  end

  // Every 32-bit form is already correctly signed, so one sign extension covers RV32/RV64
  assign o_imm_c = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes at the input, then holds results in
// a two-entry skid buffer (main M drives the outputs, skid S absorbs one overflow).
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input logic           clk,
  input logic           rst,
  imm_gen_stage_if.slave bus
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  skid_state_t       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_m_imm;
  logic [TAG_W-1:0]  r_m_tag;
  logic              r_m_ill;
  logic [XLEN-1:0]   r_s_imm;
  logic [TAG_W-1:0]  r_s_tag;
  logic              r_s_ill;

  logic [XLEN-1:0]   w_dec_imm;
  logic              w_dec_ill;
  logic              w_accept;
  logic              w_consume;

  imm_gen_stage_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr     (bus.in_instr),
    .i_imm_src   (bus.in_imm_src),
    .o_imm_c     (w_dec_imm),
    .o_illegal_c (w_dec_ill)
  );

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_consume = r_out_valid && bus.out_ready;

  // Occupancy FSM with M/S datapath; flush dominates any same-cycle transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m_imm     <= '0;
      r_m_tag     <= '0;
      r_m_ill     <= 1'b0;
      r_s_imm     <= '0;
      r_s_tag     <= '0;
      r_s_ill     <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_imm     <= w_dec_imm;
            r_m_tag     <= bus.in_tag;
            r_m_ill     <= w_dec_ill;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            r_m_imm <= w_dec_imm;
            r_m_tag <= bus.in_tag;
            r_m_ill <= w_dec_ill;
          end else if (w_accept) begin
            r_s_imm    <= w_dec_imm;
            r_s_tag    <= bus.in_tag;
            r_s_ill    <= w_dec_ill;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_consume) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen
          if (w_consume) begin
            r_m_imm    <= r_s_imm;
            r_m_tag    <= r_s_tag;
            r_m_ill    <= r_s_ill;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_imm     = r_m_imm;
  assign bus.out_tag     = r_m_tag;
  assign bus.out_illegal = r_m_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: RV32 and RV64 instances driven in lockstep, checked against
// an arithmetic immediate model and a queue-based occupancy/ordering model.
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  ent_t q[$];
  int   seen[$];
  bit   record_seen;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate value computed as a signed sum of weighted instruction fields
  function automatic ent_t model(input logic [31:0] instr, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tag);
    longint v;
    ent_t   e;
    v     = 0;
    e.ill = 1'b0;
    e.tag = tag;
    case (src)
      3'd0: v = (instr[31] ? -64'sd2048 : 64'sd0) + longint'(instr[30:20]);
      3'd1: v = (instr[31] ? -64'sd2048 : 64'sd0) + longint'(instr[30:25]) * 32
                + longint'(instr[11:7]);
      3'd2: v = (instr[31] ? -64'sd4096 : 64'sd0) + longint'(instr[7]) * 2048
                + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
      3'd3: v = (instr[31] ? -64'sd2147483648 : 64'sd0) + longint'(instr[30:12]) * 4096;
      3'd4: v = (instr[31] ? -64'sd1048576 : 64'sd0) + longint'(instr[19:12]) * 4096
                + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
      3'd5: v = longint'(instr[19:15]);
      default: begin
        v     = 0;
        e.ill = 1'b1;
      end
    endcase
    e.imm = 64'(v);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag, input bit ordy, input bit fl);
    bus32.in_valid   = v;
    bus32.in_instr   = instr;
    bus32.in_imm_src = imm_src_t'(src);
    bus32.in_tag     = tag;
    bus32.out_ready  = ordy;
    bus32.flush      = fl;
    bus64.in_valid   = v;
    bus64.in_instr   = instr;
    bus64.in_imm_src = imm_src_t'(src);
    bus64.in_tag     = tag;
    bus64.out_ready  = ordy;
    bus64.flush      = fl;
  endtask

  // Outputs must always reflect the head of the model queue (covers stall stability)
  task automatic check_outputs();
    chk("out_valid32", bus32.out_valid, q.size() > 0);
    chk("out_valid64", bus64.out_valid, q.size() > 0);
    chk("in_ready32", bus32.in_ready, q.size() < 2);
    chk("in_ready64", bus64.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("imm64", bus64.out_imm, q[0].imm);
      chk("imm32", bus32.out_imm, {32'd0, q[0].imm[31:0]});
      chk("tag64", bus64.out_tag, q[0].tag);
      chk("tag32", bus32.out_tag, q[0].tag);
      chk("ill64", bus64.out_illegal, q[0].ill);
      chk("ill32", bus32.out_illegal, q[0].ill);
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] instr, input logic [2:0] src,
                     input logic [TAG_W-1:0] tag, input bit ordy, input bit fl);
    bit   acc;
    bit   con;
    ent_t e;
    ent_t dropped;
    drive(v, instr, src, tag, ordy, fl);
    check_outputs();
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && ordy;
    e   = model(instr, src, tag);
    if (con && !fl && record_seen) seen.push_back(int'(bus64.out_tag));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (con) dropped = q.pop_front();
      if (acc) q.push_back(e);
    end
    #2;
  endtask

  initial begin
    int k;
    total       = 0;
    bad         = 0;
    record_seen = 1'b0;
    rst         = 1'b1;
    drive(0, 32'd0, 3'd0, '0, 0, 0);
    #12;
    chk("rst_out_valid", bus64.out_valid, 0);
    chk("rst_out_imm", bus64.out_imm, 0);
    chk("rst_out_tag", bus64.out_tag, 0);
    chk("rst_out_illegal", bus64.out_illegal, 0);
    chk("rst_in_ready", bus64.in_ready, 1);
    chk("rst_out_valid32", bus32.out_valid, 0);
    rst = 1'b0;

    // Directed decode examples, one cycle latency from empty
    cyc(1, 32'hFFF00093, 3'd0, 5'd1, 1, 0);
    chk("t1_valid", bus32.out_valid, 1);
    chk("t1_I_imm32", bus32.out_imm, 64'hFFFFFFFF);
    chk("t1_I_ill", bus32.out_illegal, 0);
    cyc(1, 32'hFE000CE3, 3'd2, 5'd2, 1, 0);
    chk("t2_B_imm32", bus32.out_imm, 64'hFFFFFFF8);
    cyc(1, 32'hFFDFF06F, 3'd4, 5'd3, 1, 0);
    chk("t2_J_imm32", bus32.out_imm, 64'hFFFFFFFC);
    cyc(1, 32'h800000B7, 3'd3, 5'd4, 1, 0);
    chk("t3_U_imm64", bus64.out_imm, 64'hFFFFFFFF80000000);
    chk("t3_U_imm32", bus32.out_imm, 64'h80000000);
    cyc(1, 32'h0007D073, 3'd5, 5'd5, 1, 0);
    chk("t3_Z_imm64", bus64.out_imm, 64'h000000000000000F);
    cyc(1, 32'hFFFFFFFF, 3'd6, 5'd6, 1, 0);
    chk("t3_rsv_imm64", bus64.out_imm, 0);
    chk("t3_rsv_ill", bus64.out_illegal, 1);
    repeat (2) cyc(0, 32'd0, 3'd0, '0, 1, 0);

    // Backpressure: tags 1..4 with out_ready low for three cycles
    seen.delete();
    record_seen = 1'b1;
    cyc(1, 32'h00100093, 3'd0, 5'd1, 0, 0);
    cyc(1, 32'h00200093, 3'd0, 5'd2, 0, 0);
    chk("bp_in_ready_low", bus64.in_ready, 0);
    chk("bp_hold_tag1", bus64.out_tag, 1);
    cyc(1, 32'h00300093, 3'd0, 5'd3, 0, 0);
    chk("bp_still_tag1", bus64.out_tag, 1);
    k = 3;
    for (int c = 0; c < 20 && k <= 4; c++) begin
      bit r;
      r = (q.size() < 2);
      cyc(1, 32'(k) << 20, 3'd0, 5'(k), 1, 0);
      if (r) k++;
    end
    repeat (4) cyc(0, 32'd0, 3'd0, '0, 1, 0);
    record_seen = 1'b0;
    chk("bp_count", 64'(seen.size()), 4);
    for (int i = 0; i < seen.size(); i++) chk("bp_order", 64'(seen[i]), 64'(i + 1));

    // Flush while full, with a simultaneous input that must be dropped
    cyc(1, 32'h00500093, 3'd0, 5'd5, 0, 0);
    cyc(1, 32'h00600093, 3'd0, 5'd6, 0, 0);
    cyc(1, 32'h00700093, 3'd0, 5'd7, 1, 1);
    chk("fl_out_valid", bus64.out_valid, 0);
    chk("fl_in_ready", bus64.in_ready, 1);
    repeat (3) cyc(0, 32'd0, 3'd0, '0, 1, 0);

    // Asynchronous reset between edges
    cyc(1, 32'h00900093, 3'd0, 5'd9, 0, 0);
    cyc(1, 32'h00A00093, 3'd0, 5'd10, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid64", bus64.out_valid, 0);
    chk("arst_out_valid32", bus32.out_valid, 0);
    chk("arst_in_ready", bus64.in_ready, 1);
    #1;
    rst = 1'b0;
    q.delete();
    cyc(1, 32'h00B00093, 3'd0, 5'd11, 0, 0);
    chk("arst_first_valid", bus64.out_valid, 1);
    chk("arst_first_tag", bus64.out_tag, 11);
    repeat (2) cyc(0, 32'd0, 3'd0, '0, 1, 0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
          TAG_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    repeat (4) cyc(0, 32'd0, 3'd0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
